riscv_test_monitor: RTL and testbench
=====================================

# riscv_test_monitor

Synthesizable pass/fail/timeout monitor for riscv-tests runs, sitting beside `Core` and observing its retire and store streams. It generalises the fixed "PC reaches 0x44, check x3 == 1" bench check. Detection works by PASS_PC/gp match, by a riscv-tests `tohost` store, or both. A cycle watchdog flags hung tests. Results stay sticky until cleared, so a regression wrapper or an FPGA status LED can read them.

## Interface
- `XLEN`, 32: data/address width.
- `PASS_PC`, 32'h44: PC of the pass/fail landing point in PC mode.
- `TOHOST_ADDR`, 32'h1000: store address watched in tohost mode.
- `TIMEOUT`, 5000: watchdog limit in cycles; must be ≥ 2.
- `MODE`, 2: 0 = PC/gp only, 1 = tohost only, 2 = both.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous restart of a run.
- `retire_valid` in 1: one instruction retires this cycle.
- `retire_pc` in XLEN: PC of the retiring instruction.
- `gp_value` in XLEN: current x3 (gp) value.
- `st_valid` in 1: data store issued this cycle.
- `st_addr` in XLEN: store address.
- `st_data` in XLEN: store data.
- `done` out 1: run finished (any outcome).
- `passed` out 1: test passed.
- `failed` out 1: test failed.
- `timed_out` out 1: watchdog expired.
- `fail_num` out XLEN-1: failing test number (gp>>1 or st_data>>1).
- `cycle_count` out 32: cycles spent in RUN, saturating.
- `retire_count` out 32: retired instructions in RUN, saturating.

## Operation
- States: RUN, PASS, FAIL, TMO. Reset and `clear` both enter RUN with all counters and outputs zero.
- PC event, enabled when MODE ≠ 1: `retire_valid && retire_pc == PC_PASS`.
  - gp == 1 → PASS.
  - Otherwise → FAIL with `fail_num = gp_value >> 1`.
- tohost event, enabled when MODE ≠ 0: `st_valid && st_addr == TOHOST_ADDR && st_data != 0`.
  - `st_data == 1` → PASS.
  - Otherwise → FAIL with `fail_num = st_data >> 1`.
  - A zero store is ignored.
- Watchdog: in RUN with no event, when `cycle_count == TIMEOUT-1`, go to TMO.
- Priority within one cycle: tohost > PC > watchdog.
- PASS, FAIL and TMO are terminal and sticky. Later events are ignored until `clear` or `rst`.
- In terminal states, counters hold their values.
- Status outputs:
  - `done` = state ≠ RUN.
  - `passed`, `failed`, `timed_out` are one-hot decodes of the terminal state.
  - `fail_num` is 0 unless state is FAIL.
- `cycle_count` increments every cycle in RUN. `retire_count` increments on `retire_valid` in RUN. Both saturate at 2^32-1.

## Timing
- All outputs are registered. The event cycle is sampled at edge N; status is visible after edge N, one cycle of latency.
- Watchdog: with no event, `timed_out` rises after the edge at which `cycle_count` would reach TIMEOUT. `cycle_count` freezes at TIMEOUT-1.
- `clear` wins over any same-cycle event. The next state is RUN, so that event is lost.
- `rst` low asynchronously forces RUN and zeros every output, including mid-run and in terminal states. Release is synchronised by the system reset block.
- The input cycle after `clear` counts as RUN cycle 0.

## Structure
- Shared package `riscv_test_pkg`:
  - state enum `mon_state_t`;
  - MODE constants `MON_MODE_PC`, `MON_MODE_TOHOST`, `MON_MODE_BOTH`;
  - default `TOHOST_ADDR` and `PASS_PC`.
- Sub-module `sat_counter` (WIDTH param; `en`, `clr`, `q`), instantiated twice for the two counters.
- Per-test benches instantiate Core + monitor and write `passed`/`failed` to the result file, instead of probing `core.pc` and `core.rs[3]`.

## Test plan
- MODE=0: retire PC 0x44 with gp=1 at cycle 100 → `passed=1`, `done=1` one cycle later; `cycle_count=100` holds.
- MODE=0: retire PC 0x44 with gp=7 → `failed=1`, `fail_num=3`.
- MODE=1: store 0x1000/data 0 then data 0x15 → ignored, then `failed=1`, `fail_num=10`. A PC 0x44 retire alone → no effect.
- MODE=2: tohost data 1 and PC 0x44 with gp=5 in the same cycle → `passed=1` (tohost priority).
- TIMEOUT=20, no events → `timed_out=1` after the 20th edge, `cycle_count=19`. A later pass event → no change.
- `clear` while in PASS, and `rst` low mid-run at cycle 7 → all outputs 0, counters restart from 0.

Source files
------------

// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the riscv-tests pass/fail/timeout monitor.
// Holds the monitor state enum, detection-mode codes and default addresses.
package riscv_test_pkg;

   typedef enum logic [1:0] {
      MON_RUN,
      MON_PASS,
      MON_FAIL,
      MON_TMO
   } mon_state_t;

   localparam int unsigned MON_MODE_PC     = 0;
   localparam int unsigned MON_MODE_TOHOST = 1;
   localparam int unsigned MON_MODE_BOTH   = 2;

   localparam logic [31:0] MON_PASS_PC     = 32'h0000_0044;
   localparam logic [31:0] MON_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Observation bundle between Core and the test monitor.
// master: core side (retire/store streams in, status back); slave: monitor.
interface riscv_test_monitor_if #(
   parameter int XLEN = 32
);
   logic            retire_valid;
   logic [XLEN-1:0] retire_pc;
   logic [XLEN-1:0] gp_value;
   logic            st_valid;
   logic [XLEN-1:0] st_addr;
   logic [XLEN-1:0] st_data;
   logic            done;
   logic            passed;
   logic            failed;
   logic            timed_out;
   logic [XLEN-2:0] fail_num;
   logic [31:0]     cycle_count;
   logic [31:0]     retire_count;

   modport master (
      output retire_valid, retire_pc, gp_value,
      output st_valid, st_addr, st_data,
      input  done, passed, failed, timed_out,
      input  fail_num, cycle_count, retire_count
   );

   modport slave (
      input  retire_valid, retire_pc, gp_value,
      input  st_valid, st_addr, st_data,
      output done, passed, failed, timed_out,
      output fail_num, cycle_count, retire_count
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Ports: clk, rst (active-low), en (count), clr (to zero), q (value).
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign q = cnt_q;
endmodule

// File: rtl/riscv_test_monitor.sv
// Sticky pass/fail/timeout monitor for riscv-tests runs (PC/gp and tohost).
// Ports: clk, rst (async active-low), clear (sync restart), bus (slave view).
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] PASS_PC     = XLEN'(MON_PASS_PC),
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(MON_TOHOST_ADDR),
   parameter int unsigned     TIMEOUT     = 5000,
   parameter int unsigned     MODE        = MON_MODE_BOTH
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   riscv_test_monitor_if.slave bus
);
   localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

   mon_state_t      state_q;
   mon_state_t      state_d;
   logic [XLEN-2:0] fail_num_q;
   logic [XLEN-2:0] fail_num_d;
   logic [31:0]     cyc_cnt;
   logic [31:0]     ret_cnt;
   logic            run;
   logic            th_hit;
   logic            pc_hit;
   logic            cyc_en;
   logic            ret_en;

   assign run = (state_q == MON_RUN);

   assign th_hit = (MODE != MON_MODE_PC) && bus.st_valid &&
                   (bus.st_addr == TOHOST_ADDR) && (bus.st_data != '0);

   assign pc_hit = (MODE != MON_MODE_TOHOST) && bus.retire_valid &&
                   (bus.retire_pc == PASS_PC);

   // tohost outranks PC, which outranks the watchdog
   always_comb begin
      state_d    = state_q;
      fail_num_d = fail_num_q;
      if (clear) begin
         state_d    = MON_RUN;
         fail_num_d = '0;
      end else if (run) begin
         if (th_hit) begin
            if (bus.st_data == XLEN'(1)) begin
               state_d = MON_PASS;
            end else begin
               state_d    = MON_FAIL;
               fail_num_d = (XLEN-1)'(bus.st_data >> 1);
            end
         end else if (pc_hit) begin
            if (bus.gp_value == XLEN'(1)) begin
               state_d = MON_PASS;
            end else begin
               state_d    = MON_FAIL;
               fail_num_d = (XLEN-1)'(bus.gp_value >> 1);
            end
         end else if (cyc_cnt == WDOG_LAST) begin
            state_d = MON_TMO;
         end
      end
   end

   // cycle count only advances while staying in RUN, so it freezes on the
   // terminating edge (TIMEOUT-1 for a watchdog expiry)
   assign cyc_en = run && !clear && (state_d == MON_RUN);
   assign ret_en = run && !clear && bus.retire_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= MON_RUN;
         fail_num_q <= '0;
      end else begin
         state_q    <= state_d;
         fail_num_q <= fail_num_d;
      end
   end

   sat_counter #(.WIDTH(32)) u_cyc_cnt (
      .clk (clk),
      .rst (rst),
      .en  (cyc_en),
      .clr (clear),
      .q   (cyc_cnt)
   );

   sat_counter #(.WIDTH(32)) u_ret_cnt (
      .clk (clk),
      .rst (rst),
      .en  (ret_en),
      .clr (clear),
      .q   (ret_cnt)
   );

   assign bus.done         = !run;
   assign bus.passed       = (state_q == MON_PASS);
   assign bus.failed       = (state_q == MON_FAIL);
   assign bus.timed_out    = (state_q == MON_TMO);
   assign bus.fail_num     = fail_num_q;
   assign bus.cycle_count  = cyc_cnt;
   assign bus.retire_count = ret_cnt;
endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomised + directed bench for riscv_test_monitor.
// Three monitors (MODE 0/1/2) see the same streams; a reference model checks each.
module tb_riscv_test_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] gp_value = '0;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   logic        o_done [3];
   logic        o_pass [3];
   logic        o_fail [3];
   logic        o_tmo  [3];
   logic [30:0] o_fn   [3];
   logic [31:0] o_cc   [3];
   logic [31:0] o_rc   [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      riscv_test_monitor_if #(.XLEN(32)) bus ();

      assign bus.retire_valid = retire_valid;
      assign bus.retire_pc    = retire_pc;
      assign bus.gp_value     = gp_value;
      assign bus.st_valid     = st_valid;
      assign bus.st_addr      = st_addr;
      assign bus.st_data      = st_data;

      assign o_done[g] = bus.done;
      assign o_pass[g] = bus.passed;
      assign o_fail[g] = bus.failed;
      assign o_tmo[g]  = bus.timed_out;
      assign o_fn[g]   = bus.fail_num;
      assign o_cc[g]   = bus.cycle_count;
      assign o_rc[g]   = bus.retire_count;

      riscv_test_monitor #(
         .XLEN        (32),
         .PASS_PC     (32'h44),
         .TOHOST_ADDR (32'h1000),
         .TIMEOUT     ((g == 2) ? 20 : 300),
         .MODE        (g)
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .clear (clear),
         .bus   (bus)
      );
   end

   // reference model: outcome 0=running 1=pass 2=fail 3=timeout
   int          m_st [3];
   longint      m_fn [3];
   longint      m_cc [3];
   longint      m_rc [3];
   localparam longint SAT = 64'hFFFF_FFFF;

   function automatic int tmo_of(int k);
      return (k == 2) ? 20 : 300;
   endfunction

   task automatic model_zero();
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_fn[k] = 0; m_cc[k] = 0; m_rc[k] = 0;
      end
   endtask

   task automatic model_edge();
      bit tohost, pcev;
      for (int k = 0; k < 3; k++) begin
         if (clear) begin
            m_st[k] = 0; m_fn[k] = 0; m_cc[k] = 0; m_rc[k] = 0;
         end else if (m_st[k] == 0) begin
            tohost = (k != 0) && st_valid && st_addr == 32'h1000 && st_data != 0;
            pcev   = (k != 1) && retire_valid && retire_pc == 32'h44;
            if (retire_valid && m_rc[k] < SAT) m_rc[k] = m_rc[k] + 1;
            if (tohost) begin
               m_st[k] = (st_data == 1) ? 1 : 2;
               m_fn[k] = (st_data == 1) ? 0 : longint'(st_data) / 2;
            end else if (pcev) begin
               m_st[k] = (gp_value == 1) ? 1 : 2;
               m_fn[k] = (gp_value == 1) ? 0 : longint'(gp_value) / 2;
            end else if (m_cc[k] + 1 == tmo_of(k)) begin
               m_st[k] = 3;
            end else if (m_cc[k] < SAT) begin
               m_cc[k] = m_cc[k] + 1;
            end
         end
      end
   endtask

   task automatic chk(string tag, longint got, longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic cmp_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d_done", k), o_done[k], m_st[k] != 0);
         chk($sformatf("d%0d_pass", k), o_pass[k], m_st[k] == 1);
         chk($sformatf("d%0d_fail", k), o_fail[k], m_st[k] == 2);
         chk($sformatf("d%0d_tmo", k),  o_tmo[k],  m_st[k] == 3);
         chk($sformatf("d%0d_fnum", k), o_fn[k],   m_fn[k]);
         chk($sformatf("d%0d_cyc", k),  o_cc[k],   m_cc[k]);
         chk($sformatf("d%0d_ret", k),  o_rc[k],   m_rc[k]);
      end
   endtask

   task automatic idle();
      clear = 0; retire_valid = 0; retire_pc = 0; gp_value = 0;
      st_valid = 0; st_addr = 0; st_data = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      cmp_all();
   endtask

   task automatic do_clear();
      idle();
      clear = 1;
      cyc();
      clear = 0;
   endtask

   task automatic async_rst();
      rst = 0;
      #1;
      model_zero();
      cmp_all();
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      idle();
      model_zero();
      #12;
      cmp_all();
      @(negedge clk);
      rst = 1;

      // MODE0 pass at cycle 100
      for (int i = 0; i < 100; i++) cyc();
      retire_valid = 1; retire_pc = 32'h44; gp_value = 1;
      cyc();
      idle();
      cyc();
      chk("m0_pass", o_pass[0], 1);
      chk("m0_done", o_done[0], 1);
      chk("m0_cyc100", o_cc[0], 100);

      // clear in PASS, then MODE0 fail gp=7
      do_clear();
      chk("clr_pass", o_pass[0], 0);
      retire_valid = 1; retire_pc = 32'h44; gp_value = 7;
      cyc();
      idle();
      chk("m0_fail", o_fail[0], 1);
      chk("m0_fnum", o_fn[0], 3);
      chk("m1_ignore_pc", o_done[1], 0);

      // MODE1: PC retire ignored, zero store ignored, 0x15 fails
      do_clear();
      retire_valid = 1; retire_pc = 32'h44; gp_value = 1;
      cyc();
      idle();
      chk("m1_pc_noeff", o_done[1], 0);
      st_valid = 1; st_addr = 32'h1000; st_data = 0;
      cyc();
      chk("m1_zero_st", o_done[1], 0);
      st_data = 32'h15;
      cyc();
      idle();
      chk("m1_fail", o_fail[1], 1);
      chk("m1_fnum", o_fn[1], 10);

      // MODE2: tohost pass beats PC fail in the same cycle
      do_clear();
      st_valid = 1; st_addr = 32'h1000; st_data = 1;
      retire_valid = 1; retire_pc = 32'h44; gp_value = 5;
      cyc();
      idle();
      chk("m2_prio", o_pass[2], 1);

      // MODE2 watchdog (TIMEOUT=20), later pass ignored
      do_clear();
      for (int i = 0; i < 19; i++) cyc();
      chk("m2_pre_tmo", o_tmo[2], 0);
      cyc();
      chk("m2_tmo", o_tmo[2], 1);
      chk("m2_cyc19", o_cc[2], 19);
      st_valid = 1; st_addr = 32'h1000; st_data = 1;
      cyc();
      idle();
      chk("m2_sticky", o_tmo[2], 1);

      // async reset mid-run at cycle 7
      do_clear();
      for (int i = 0; i < 7; i++) begin
         retire_valid = 1; retire_pc = 32'h100;
         cyc();
      end
      idle();
      async_rst();
      chk("rst_cyc0", o_cc[0], 0);
      cyc();
      chk("rst_restart", o_cc[0], 1);

      // randomised streams
      for (int i = 0; i < 4000; i++) begin
         clear        = ($urandom % 40) == 0;
         retire_valid = $urandom % 2;
         retire_pc    = (($urandom % 12) == 0) ? 32'h44 : ($urandom & 32'hFFFC);
         gp_value     = (($urandom % 3) == 0) ? 1 : ($urandom % 64);
         st_valid     = ($urandom % 3) == 0;
         st_addr      = (($urandom % 6) == 0) ? 32'h1000 : ($urandom & 32'h1FFC);
         case ($urandom % 3)
            0: st_data = 0;
            1: st_data = 1;
            default: st_data = $urandom;
         endcase
         if (($urandom % 400) == 0) begin
            idle();
            async_rst();
         end else begin
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
